ref_angle_sequencer: RTL and testbench
======================================

Name: ref_angle_sequencer

Overview:
- Multi-channel circular buffer of reference angles. Feeds the downstream beam/phase datapath one angle vector per `ready` strobe.
- Loaded serially via `fill`. Supports one-shot consume mode and loop (replay) mode, with full/empty/count status and overflow/underflow flags.
- Sits between the control/config loader and the angle consumers.

Parameters:
- ANGLE_DEPTH, 10, bits per angle.
- NUM_VALUES, 20, buffer depth in entries (≥2).
- NUM_CH, 2, angles per entry, packed with channel 0 in the LSBs.
- CNT_W, $clog2(NUM_VALUES+1), width of count (derived localparam, not overridable).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous flush.
- loop_mode  input  1  0 = one-shot consume, 1 = loop replay.
- fill  input  1  write angle_in this cycle.
- angle_in  input  NUM_CH*ANGLE_DEPTH  packed angle vector to store.
- ready  input  1  request next angle vector.
- angle_out  output  NUM_CH*ANGLE_DEPTH  registered output vector.
- out_valid  output  1  angle_out updated from a stored entry this cycle.
- count  output  CNT_W  entries held.
- empty  output  1  count==0.
- full  output  1  count==NUM_VALUES.
- overflow  output  1  one-cycle pulse: write dropped.
- underflow  output  1  one-cycle pulse: ready with empty buffer.

Behaviour:
- Reset (async): wr_ptr=0, rd_ptr=0, count=0, angle_out=0, out_valid=0, overflow=0, underflow=0. Memory contents need not be cleared.
- empty and full are combinational from count. At reset empty=1, full=0.
- Pointers wrap from NUM_VALUES-1 to 0.
- Priority: rst_n > clear > normal operation.
- clear: zeroes pointers, count, angle_out, out_valid and the flags next edge. fill/ready in the same cycle are ignored.
- Write (fill, not full): mem[wr_ptr]<=angle_in, wr_ptr++, count++.
- Write while full with no read that cycle: dropped, overflow=1 next cycle, state unchanged.
- Read, one-shot (ready, loop_mode=0, count>0):
  - angle_out<=mem[rd_ptr], out_valid=1 next cycle.
  - rd_ptr++, count--.
- Read, loop (ready, loop_mode=1, count>0):
  - angle_out<=mem[rd_ptr], out_valid=1 next cycle.
  - The same entry is re-appended: mem[wr_ptr]<=mem[rd_ptr], rd_ptr++, wr_ptr++, count unchanged.
  - The stored sequence therefore replays cyclically in write order.
- Read when count==0 (either mode): angle_out<=0, out_valid=0, underflow=1 next cycle, pointers unchanged.
- No ready: angle_out holds its last value; out_valid=0 next cycle.
- fill+ready same cycle, one-shot:
  - count>0: read and write both occur, count unchanged. This also applies when full, since the read frees the slot and no overflow is raised.
  - count==0: write accepted (count→1), read underflows. No bypass of angle_in to angle_out.
- fill+ready same cycle, loop mode: ready wins; the fill is dropped and overflow pulses. If count==0, the fill is accepted and the read underflows.
- loop_mode is sampled per cycle. Toggling it preserves contents and pointers.
- Read latency: 1 cycle from ready edge to angle_out/out_valid.
- Write-to-readable latency: an entry written at edge N is readable by ready sampled at edge N+1.

Test Plan:
- Basic one-shot (NUM_CH=2):
  - Stimulus: reset, fill {0x001,0x002}, {0x003,0x004}, {0x3FF,0x000}, then ready ×4.
  - Required: angle_out = 0x002_001, 0x004_003, 0x000_3FF with out_valid=1.
  - 4th read: angle_out=0, out_valid=0, underflow=1, count=0, empty=1.
- Full/overflow:
  - Stimulus: fill 20 distinct vectors, then 21st fill alone.
  - Required: full=1 and count=20 after the 20th; overflow pulses one cycle on the 21st; the 21st value never appears on reads.
- Wrap-around:
  - Stimulus: fill values 1..15, read 10, fill values 16..30, then read 20.
  - Required: count=20 before the drain; reads return 11..30 in order; empty=1 at end.
- Loop mode:
  - Stimulus: fill A,B,C; loop_mode=1; ready ×7.
  - Required: outputs A,B,C,A,B,C,A; count stays 3.
  - Then loop_mode=0 and ready ×3 returns B,C,A and count=0.
- Simultaneous fill+ready:
  - Stimulus: when full in one-shot, fill X with ready.
  - Required: oldest entry out, X accepted, count=20, no overflow.
  - Stimulus: at count=0, fill Y with ready.
  - Required: underflow=1, count=1, next ready returns Y.
- clear/reset mid-operation:
  - Stimulus: with count=7 and ready held, assert clear for one cycle.
  - Required: next edge count=0, angle_out=0, out_valid=0, empty=1.
  - Stimulus: refill then deassert rst_n asynchronously mid-cycle.
  - Required: outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ref_angle_sequencer.sv
// ref_angle_sequencer
// Multi-channel circular buffer of reference angle vectors. Entries are loaded
// serially with `fill` and handed to the beam/phase datapath one vector per
// `ready` strobe. In one-shot mode a read consumes the entry. In loop mode the
// entry just read is re-appended at the tail, so the stored sequence replays
// cyclically in write order.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous flush of pointers, count, output and flags
//   loop_mode   0 = one-shot consume, 1 = loop replay (sampled every cycle)
//   fill        store angle_in this cycle
//   angle_in    packed angle vector, channel 0 in the LSBs
//   ready       request the next angle vector
//   angle_out   registered output vector (1-cycle read latency)
//   out_valid   angle_out was loaded from a stored entry this cycle
//   count       entries held; empty/full are decoded from it
//   overflow    one-cycle pulse: a write was dropped
//   underflow   one-cycle pulse: ready arrived with an empty buffer
module ref_angle_sequencer #(
  parameter int ANGLE_DEPTH = 10,
  parameter int NUM_VALUES  = 20,
  parameter int NUM_CH      = 2,
  localparam int CNT_W      = $clog2(NUM_VALUES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          loop_mode,
  input  logic                          fill,
  input  logic [NUM_CH*ANGLE_DEPTH-1:0] angle_in,
  input  logic                          ready,
  output logic [NUM_CH*ANGLE_DEPTH-1:0] angle_out,
  output logic                          out_valid,
  output logic [CNT_W-1:0]              count,
  output logic                          empty,
  output logic                          full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int W     = NUM_CH * ANGLE_DEPTH;
  localparam int PTR_W = $clog2(NUM_VALUES);

  logic [W-1:0]     mem [NUM_VALUES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             do_read;    // ready with at least one entry stored
  logic             loop_copy;  // loop-mode read re-appending its entry
  logic             fill_ok;    // external write accepted
  logic             drop;       // external write discarded
  logic             wr_en;
  logic [W-1:0]     rd_data;
  logic [W-1:0]     wr_data;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(NUM_VALUES));

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_VALUES - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    do_read   = ready && !empty;
    loop_copy = loop_mode && do_read;
    // A loop-mode read owns the write port, so a concurrent fill loses. In
    // one-shot mode a concurrent read frees the slot a full buffer needs.
    fill_ok   = fill && !loop_copy && (!full || do_read);
    drop      = fill && !fill_ok;
    wr_en     = !clear && (loop_copy || fill_ok);
    rd_data   = mem[rd_ptr];
    wr_data   = loop_copy ? rd_data : angle_in;
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are meaningful, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      angle_out <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      angle_out <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= next_ptr(wr_ptr);
      if (do_read) rd_ptr <= next_ptr(rd_ptr);

      // Loop reads leave count unchanged; one-shot reads consume an entry.
      if (fill_ok && !(do_read && !loop_mode))
        count <= count + CNT_W'(1);
      else if (!fill_ok && do_read && !loop_mode)
        count <= count - CNT_W'(1);

      if (do_read)    angle_out <= rd_data;
      else if (ready) angle_out <= '0;

      out_valid <= do_read;
      overflow  <= drop;
      underflow <= ready && empty;
    end
  end

endmodule

// File: tb/tb_ref_angle_sequencer.sv
// Directed testbench for ref_angle_sequencer with the default parameters
// (ANGLE_DEPTH=10, NUM_VALUES=20, NUM_CH=2). Each scenario task drives its
// stimulus and compares outputs against hand-computed values 1 ns after the
// active clock edge.
module tb_ref_angle_sequencer;

  localparam int AD  = 10;
  localparam int NV  = 20;
  localparam int NC  = 2;
  localparam int W   = NC * AD;
  localparam int CW  = $clog2(NV + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          loop_mode = 1'b0;
  logic          fill = 1'b0;
  logic [W-1:0]  angle_in = '0;
  logic          ready = 1'b0;
  logic [W-1:0]  angle_out;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  ref_angle_sequencer #(.ANGLE_DEPTH(AD), .NUM_VALUES(NV), .NUM_CH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .loop_mode(loop_mode),
    .fill(fill), .angle_in(angle_in), .ready(ready),
    .angle_out(angle_out), .out_valid(out_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Pack {ch1, ch0} with channel 0 in the LSBs.
  function automatic logic [W-1:0] mk(input int ch0, input int ch1);
    logic [AD-1:0] a;
    logic [AD-1:0] b;
    a = AD'(ch0);
    b = AD'(ch1);
    return {b, a};
  endfunction

  // One clock cycle with the given strobes, then settle 1 ns past the edge.
  task automatic cyc(input logic f, input logic [W-1:0] d, input logic r);
    fill = f; angle_in = d; ready = r;
    @(posedge clk);
    #1;
    fill = 1'b0; ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; loop_mode = 1'b0; fill = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 0)     begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (angle_out !== 0 || out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got out=%h v=%b ov=%b un=%b want 0", angle_out, out_valid, overflow, underflow); end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_v [3];
    exp_v[0] = 20'h00801; exp_v[1] = 20'h01003; exp_v[2] = 20'h003FF;
    do_reset();
    cyc(1'b1, mk(12'h001, 12'h002), 1'b0);
    cyc(1'b1, mk(12'h003, 12'h004), 1'b0);
    cyc(1'b1, mk(12'h3FF, 12'h000), 1'b0);
    n_checks++; if (count !== 3) begin n_fail++; $display("FAIL oneshot_count3: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== exp_v[i] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL oneshot_read%0d: got %h v=%b want %h v=1", i, angle_out, out_valid, exp_v[i]); end
    end
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (angle_out !== 0 || out_valid !== 1'b0 || underflow !== 1'b1 || count !== 0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_underflow: got out=%h v=%b un=%b cnt=%0d e=%b want 0 0 1 0 1",
                         angle_out, out_valid, underflow, count, empty); end
    cyc(1'b0, '0, 1'b0);
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got %b want 0", underflow); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < NV; i++) cyc(1'b1, mk(100 + i, 200 + i), 1'b0);
    n_checks++; if (full !== 1'b1 || count !== NV) begin
      n_fail++; $display("FAIL full_after_20: got full=%b cnt=%0d want 1 20", full, count); end
    cyc(1'b1, mk(10'h3AA, 10'h3AA), 1'b0);
    n_checks++; if (overflow !== 1'b1 || count !== NV) begin
      n_fail++; $display("FAIL overflow_pulse: got ov=%b cnt=%0d want 1 20", overflow, count); end
    cyc(1'b0, '0, 1'b0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clears: got %b want 0", overflow); end
    for (int i = 0; i < NV; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== mk(100 + i, 200 + i) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_drain%0d: got %h want %h", i, angle_out, mk(100 + i, 200 + i)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 1; v <= 15; v++) cyc(1'b1, mk(v, v + 512), 1'b0);
    for (int v = 1; v <= 10; v++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== mk(v, v + 512)) begin
        n_fail++; $display("FAIL wrap_first%0d: got %h want %h", v, angle_out, mk(v, v + 512)); end
    end
    for (int v = 16; v <= 30; v++) cyc(1'b1, mk(v, v + 512), 1'b0);
    n_checks++; if (count !== NV || full !== 1'b1) begin
      n_fail++; $display("FAIL wrap_count: got %0d full=%b want 20 1", count, full); end
    for (int v = 11; v <= 30; v++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== mk(v, v + 512) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_read%0d: got %h want %h", v, angle_out, mk(v, v + 512)); end
    end
    n_checks++; if (empty !== 1'b1 || count !== 0) begin
      n_fail++; $display("FAIL wrap_empty: got e=%b cnt=%0d want 1 0", empty, count); end
  endtask

  task automatic test_loop();
    logic [W-1:0] abc [3];
    abc[0] = mk(10'h0AA, 10'h011); abc[1] = mk(10'h0BB, 10'h022); abc[2] = mk(10'h0CC, 10'h033);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, abc[i], 1'b0);
    loop_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== abc[i % 3] || out_valid !== 1'b1 || count !== 3) begin
        n_fail++; $display("FAIL loop_read%0d: got %h cnt=%0d want %h cnt=3", i, angle_out, count, abc[i % 3]); end
    end
    loop_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_checks++; if (angle_out !== abc[(i + 1) % 3]) begin
        n_fail++; $display("FAIL loop_oneshot%0d: got %h want %h", i, angle_out, abc[(i + 1) % 3]); end
    end
    n_checks++; if (count !== 0) begin n_fail++; $display("FAIL loop_final_count: got %0d want 0", count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < NV; i++) cyc(1'b1, mk(300 + i, i), 1'b0);
    cyc(1'b1, mk(10'h155, 10'h2AA), 1'b1);
    n_checks++; if (angle_out !== mk(300, 0) || overflow !== 1'b0 || count !== NV) begin
      n_fail++; $display("FAIL sim_full: got %h ov=%b cnt=%0d want %h 0 20", angle_out, overflow, count, mk(300, 0)); end
    for (int i = 1; i < NV; i++) cyc(1'b0, '0, 1'b1);
    n_checks++; if (angle_out !== mk(319, 19)) begin
      n_fail++; $display("FAIL sim_drain_last_old: got %h want %h", angle_out, mk(319, 19)); end
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (angle_out !== mk(10'h155, 10'h2AA) || count !== 0) begin
      n_fail++; $display("FAIL sim_x_tail: got %h cnt=%0d want %h 0", angle_out, count, mk(10'h155, 10'h2AA)); end
    cyc(1'b1, mk(10'h0F0, 10'h00F), 1'b1);
    n_checks++; if (underflow !== 1'b1 || count !== 1 || out_valid !== 1'b0 || angle_out !== 0) begin
      n_fail++; $display("FAIL sim_empty: got un=%b cnt=%0d v=%b out=%h want 1 1 0 0", underflow, count, out_valid, angle_out); end
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (angle_out !== mk(10'h0F0, 10'h00F) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL sim_y_read: got %h want %h", angle_out, mk(10'h0F0, 10'h00F)); end
    // Loop mode: ready wins over a concurrent fill.
    cyc(1'b1, mk(1, 1), 1'b0);
    cyc(1'b1, mk(2, 2), 1'b0);
    loop_mode = 1'b1;
    cyc(1'b1, mk(9, 9), 1'b1);
    n_checks++; if (overflow !== 1'b1 || count !== 2 || angle_out !== mk(1, 1)) begin
      n_fail++; $display("FAIL sim_loop: got ov=%b cnt=%0d out=%h want 1 2 %h", overflow, count, angle_out, mk(1, 1)); end
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (angle_out !== mk(1, 1)) begin
      n_fail++; $display("FAIL sim_loop_replay: got %h want %h", angle_out, mk(1, 1)); end
    loop_mode = 1'b0;
  endtask

  task automatic test_clear_reset();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(40 + i, 7), 1'b0);
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (count !== 7 || angle_out !== mk(40, 7)) begin
      n_fail++; $display("FAIL clear_pre: got cnt=%0d out=%h want 7 %h", count, angle_out, mk(40, 7)); end
    clear = 1'b1;
    cyc(1'b1, mk(5, 5), 1'b1);
    clear = 1'b0;
    n_checks++; if (count !== 0 || angle_out !== 0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL clear: got cnt=%0d out=%h v=%b e=%b want 0 0 0 1", count, angle_out, out_valid, empty); end
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(60 + i, 3), 1'b0);
    cyc(1'b0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 0 || angle_out !== 0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: got cnt=%0d out=%h v=%b e=%b want 0 0 0 1", count, angle_out, out_valid, empty); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_full_overflow();
    test_wrap();
    test_loop();
    test_simultaneous();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
